// File: rtl/sram_arbiter.sv
// sram_arbiter: alternating IF/MEM sequencer for a fixed-latency single-port SRAM
module sram_arbiter #(
   parameter int ADDR_W    = 32,
   parameter int DATA_W    = 32,
   parameter int SRAM_WAIT = 5
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic [DATA_W-1:0] if_rdata,
   output logic              if_ready,
   input  logic              mem_r_en,
   input  logic              mem_w_en,
   input  logic [ADDR_W-1:0] mem_addr,
   input  logic [DATA_W-1:0] mem_wdata,
   output logic [DATA_W-1:0] mem_rdata,
   output logic              mem_ready,
   output logic [ADDR_W-1:0] sram_addr,
   output logic [DATA_W-1:0] sram_wdata,
   output logic              sram_we,
   output logic              sram_oe,
   input  logic [DATA_W-1:0] sram_rdata
);
   localparam int CW = $clog2(SRAM_WAIT + 1);
   typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
   state_t        r_state, w_next;
   logic [CW-1:0] r_cnt;
   logic          r_gnt_mem, r_last_mem;
   logic          w_mem, w_grant, w_pick_mem, w_last;
   assign w_mem      = mem_r_en | mem_w_en;
   assign w_grant    = (r_state == IDLE) & (if_req | w_mem);
   // on a tie, MEM wins unless it was the previous grant
   assign w_pick_mem = w_mem & (~if_req | ~r_last_mem);
   assign w_last     = r_cnt == '0;
   always_ff @(posedge clk or posedge rst)
      if (rst) r_state <= IDLE;
      else     r_state <= w_next;
   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    w_next = (if_req | w_mem) ? ACCESS : IDLE;
         ACCESS:  w_next = w_last ? DONE : ACCESS;
         default: w_next = IDLE;
      endcase
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt      <= '0;
         r_gnt_mem  <= 1'b0;
         r_last_mem <= 1'b0;
         sram_addr  <= '0;
         sram_wdata <= '0;
         sram_we    <= 1'b0;
         sram_oe    <= 1'b0;
         if_ready   <= 1'b0;
         mem_ready  <= 1'b0;
         if_rdata   <= '0;
         mem_rdata  <= '0;
      end else begin
         if_ready  <= 1'b0;
         mem_ready <= 1'b0;
         if (w_grant) begin
            r_gnt_mem  <= w_pick_mem;
            r_last_mem <= w_pick_mem;
            sram_addr  <= w_pick_mem ? mem_addr : if_addr;
            sram_wdata <= mem_wdata;
            sram_we    <= w_pick_mem & mem_w_en;
            sram_oe    <= ~(w_pick_mem & mem_w_en);
            r_cnt      <= CW'(SRAM_WAIT - 1);
         end
         if (r_state == ACCESS) begin
            if (!w_last) r_cnt <= r_cnt - CW'(1);
            else begin
               // sram_oe still marks a read during the final access cycle
               if (sram_oe && r_gnt_mem)  mem_rdata <= sram_rdata;
               if (sram_oe && !r_gnt_mem) if_rdata  <= sram_rdata;
               sram_we   <= 1'b0;
               sram_oe   <= 1'b0;
               if_ready  <= ~r_gnt_mem;
               mem_ready <= r_gnt_mem;
            end
         end
      end
   end
endmodule
